sec_seg_display: RTL

- Downstream consumer of the 0–59 seconds counter value (8-bit, counter clocked by clk_1Hz).
- Resynchronises that value into the fast board clock domain and splits it into tens/units BCD digits.
- Drives a time-multiplexed, active-low 4-digit seven-segment display; only the two rightmost digits are used.

---
 rtl/sec_disp_pkg.sv | 50 +++++
 rtl/bcd_seg_decoder.sv | 29 ++
 rtl/sec_seg_display.sv | 102 ++++++++++
 3 files changed

// File: rtl/sec_disp_pkg.sv
// Shared constants and BCD helper for the seconds seven-segment display.
// Latency: n/a (constants and a combinational function only).
// Backpressure: none.
package sec_disp_pkg;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0010000;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

   // Active-low anode selects; only the two rightmost digits are driven
   localparam logic [3:0] AN_UNITS = 4'b1110;
   localparam logic [3:0] AN_TENS  = 4'b1101;
   localparam logic [3:0] AN_OFF   = 4'hF;

   // Any code above 9 renders as a dash in the decoder
   localparam logic [3:0] DIGIT_DASH = 4'hF;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] units;
   } bcd_t;

   // Split 0..99 into tens/units using compare-and-subtract only (no divider).
   // Nine steps are enough because the caller never passes a value above 99.
   function automatic bcd_t split_bcd(input logic [7:0] v);
      bcd_t       r;
      logic [7:0] rem;
      rem    = v;
      r.tens = 4'd0;
      for (int i = 0; i < 9; i++) begin
         if (rem >= 8'd10) begin
            rem    = rem - 8'd10;
            r.tens = r.tens + 4'd1;
         end
      end
      r.units = rem[3:0];
      return r;
   endfunction

endpackage

// File: rtl/bcd_seg_decoder.sv
// BCD digit to active-low seven-segment pattern; codes 10..15 show a dash.
// Latency: combinational.
// Backpressure: none.
module bcd_seg_decoder
   import sec_disp_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   // Pattern lookup; anything that is not a decimal digit becomes a dash
   always_comb begin
      seg = SEG_DASH;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/sec_seg_display.sv
// Resyncs the 0..59 seconds value into clk and scans it onto two active-low 7-seg digits.
// Latency: 3 clk from a stable value_in change to val_q, +1 clk to seg/an/dp.
// Backpressure: none; value_in is sampled every cycle. Optional units-DP heartbeat: SEC_DP_BLINK_EN.
module sec_seg_display
   import sec_disp_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int CNT_W       = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] value_in,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

   logic [7:0]       s1;
   logic [7:0]       s2;
   logic [7:0]       val_q;
   logic [CNT_W-1:0] cnt;
   logic             sel;
   bcd_t             bcd;
   logic [3:0]       digit;
   logic [6:0]       seg_d;

   // Two-stage sample; only accept a value seen on two consecutive cycles so
   // multi-bit skew around the upstream clk_1Hz edge never reaches the display
   always_ff @(posedge clk) begin
      if (rst) begin
         s1    <= 8'd0;
         s2    <= 8'd0;
         val_q <= 8'd0;
      end else begin
         s1 <= value_in;
         s2 <= s1;
         if (s1 == s2) begin
            val_q <= s2;
         end
      end
   end

`ifdef SEC_DP_BLINK_EN
   logic hb;

   // Heartbeat flips whenever a genuinely new seconds value is captured
   always_ff @(posedge clk) begin
      if (rst) begin
         hb <= 1'b0;
      end else if ((s1 == s2) && (s2 != val_q)) begin
         hb <= ~hb;
      end
   end
`endif

   // Refresh timer; sel flips between units and tens slots every REFRESH_DIV cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         sel <= 1'b0;
      end else if (cnt == CNT_MAX) begin
         cnt <= '0;
         sel <= ~sel;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Pick the digit for the active slot; out-of-range values show dashes in both slots
   always_comb begin
      bcd   = split_bcd(val_q);
      digit = DIGIT_DASH;
      if (val_q <= 8'd99) begin
         digit = sel ? bcd.tens : bcd.units;
      end
   end

   bcd_seg_decoder u_dec (
      .digit (digit),
      .seg   (seg_d)
   );

   // Register the pad outputs so seg/an/dp switch together, one cycle behind sel/val_q
   always_ff @(posedge clk) begin
      if (rst) begin
         seg <= SEG_OFF;
         an  <= AN_OFF;
         dp  <= 1'b1;
      end else begin
         seg <= seg_d;
         an  <= sel ? AN_TENS : AN_UNITS;
`ifdef SEC_DP_BLINK_EN
         dp  <= sel ? 1'b1 : ~hb;
`else
         dp  <= 1'b1;
`endif
      end
   end

endmodule
